// File: rtl/lzd_norm_ctrl_if.sv
// Handshake and result bundle between the add/subtract stage, the
// normalization controller and the barrel shifter.
interface lzd_norm_ctrl_if #(
    parameter int unsigned SWR = 26,
    parameter int unsigned EW  = 8
);
    logic           load_i;
    logic [SWR-1:0] Add_Subt_result_i;
    logic           Carry_i;
    logic [EW-1:0]  Exp_i;

    logic           busy_o;
    logic           done_o;
    logic [EW-1:0]  Shift_Value_o;
    logic           left_right_o;
    logic [EW-1:0]  Exp_o;
    logic           overflow_o;
    logic           underflow_o;
    logic           zero_o;

    modport master (
        output load_i, Add_Subt_result_i, Carry_i, Exp_i,
        input  busy_o, done_o, Shift_Value_o, left_right_o, Exp_o,
               overflow_o, underflow_o, zero_o
    );

    modport slave (
        input  load_i, Add_Subt_result_i, Carry_i, Exp_i,
        output busy_o, done_o, Shift_Value_o, left_right_o, Exp_o,
               overflow_o, underflow_o, zero_o
    );
endinterface

// File: rtl/lzd_norm_ctrl.sv
// Normalization controller: finds the leading one with a one-bit-per-cycle
// scan and derives shift amount, direction and corrected exponent.
module lzd_norm_ctrl #(
    parameter int unsigned SWR = 26,
    parameter int unsigned EW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    lzd_norm_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_SCAN,
        S_DONE
    } state_t;

    state_t         r_state;
    logic [SWR-1:0] r_data;
    logic           r_carry;
    logic [EW-1:0]  r_exp;
    logic [EW-1:0]  r_cnt;

    logic           r_busy;
    logic           r_done;
    logic [EW-1:0]  r_shift;
    logic           r_lr;
    logic [EW-1:0]  r_exp_o;
    logic           r_ovf;
    logic           r_unf;
    logic           r_zero;

    logic [EW-1:0]  w_exp_inc;
    logic [EW-1:0]  w_exp_sub;
    logic           w_clamp;

    assign w_exp_inc = r_exp + EW'(1);
    assign w_exp_sub = r_exp - r_cnt;
    assign w_clamp   = (r_cnt > r_exp);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_carry <= 1'b0;
            r_exp   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_shift <= '0;
            r_lr    <= 1'b0;
            r_exp_o <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.load_i) begin
                        r_data  <= bus.Add_Subt_result_i;
                        r_carry <= bus.Carry_i;
                        r_exp   <= bus.Exp_i;
                        r_ovf   <= 1'b0;
                        r_unf   <= 1'b0;
                        r_zero  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (r_carry) begin
                        r_shift <= EW'(1);
                        r_lr    <= 1'b0;
                        r_exp_o <= w_exp_inc;
                        r_ovf   <= (w_exp_inc == '1);
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_data == '0) begin
                        r_zero  <= 1'b1;
                        r_shift <= '0;
                        r_exp_o <= '0;
                        r_lr    <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= S_SCAN;
                    end
                end

                // The working copy shifts left each cycle, so its MSB is
                // always the original bit at position SWR-1-r_cnt.
                S_SCAN: begin
                    if (r_data[SWR-1]) begin
                        r_lr    <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                        if (w_clamp) begin
                            r_shift <= r_exp;
                            r_exp_o <= '0;
                            r_unf   <= 1'b1;
                        end else begin
                            r_shift <= r_cnt;
                            r_exp_o <= w_exp_sub;
                        end
                    end else begin
                        r_data <= r_data << 1;
                        r_cnt  <= r_cnt + EW'(1);
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy_o        = r_busy;
    assign bus.done_o        = r_done;
    assign bus.Shift_Value_o = r_shift;
    assign bus.left_right_o  = r_lr;
    assign bus.Exp_o         = r_exp_o;
    assign bus.overflow_o    = r_ovf;
    assign bus.underflow_o   = r_unf;
    assign bus.zero_o        = r_zero;

endmodule

// File: tb/tb_lzd_norm_ctrl.sv
// Self-checking bench for lzd_norm_ctrl: directed cases plus randomized
// operations compared against a leading-zero reference model.
module tb_lzd_norm_ctrl;

    localparam int unsigned SWR = 26;
    localparam int unsigned EW  = 8;

    typedef struct packed {
        logic [EW-1:0] shift;
        logic          lr;
        logic [EW-1:0] expo;
        logic          ovf;
        logic          unf;
        logic          zero;
    } res_t;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    lzd_norm_ctrl_if #(.SWR(SWR), .EW(EW)) bus ();

    lzd_norm_ctrl #(.SWR(SWR), .EW(EW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string fmt(input res_t r);
        return $sformatf("shift=%0d lr=%0d exp=%0d ovf=%0d unf=%0d zero=%0d",
                         r.shift, r.lr, r.expo, r.ovf, r.unf, r.zero);
    endfunction

    // Reference: results and done latency straight from the arithmetic rules.
    function automatic res_t model(input logic [SWR-1:0] d, input logic c,
                                   input logic [EW-1:0] e, output int lat);
        res_t r;
        int   k;
        int   sum;
        r = '0;
        if (c) begin
            sum     = (int'(e) + 1) % 256;
            r.shift = 8'd1;
            r.expo  = 8'(sum);
            r.ovf   = (sum == 255);
            lat     = 2;
        end else if (d == 0) begin
            r.zero = 1'b1;
            lat    = 2;
        end else begin
            k = 0;
            for (int i = SWR - 1; i >= 0; i--) begin
                if (d[i]) begin
                    k = SWR - 1 - i;
                    break;
                end
            end
            lat  = 3 + k;
            r.lr = 1'b1;
            if (k > int'(e)) begin
                r.shift = e;
                r.expo  = 8'd0;
                r.unf   = 1'b1;
            end else begin
                r.shift = 8'(k);
                r.expo  = 8'(int'(e) - k);
            end
        end
        return r;
    endfunction

    function automatic res_t sample();
        res_t r;
        r.shift = bus.Shift_Value_o;
        r.lr    = bus.left_right_o;
        r.expo  = bus.Exp_o;
        r.ovf   = bus.overflow_o;
        r.unf   = bus.underflow_o;
        r.zero  = bus.zero_o;
        return r;
    endfunction

    // Leaves the bench at the negedge right after the accepting edge (n=1).
    task automatic start_op(input logic [SWR-1:0] d, input logic c, input logic [EW-1:0] e);
        @(negedge clk);
        bus.load_i            = 1'b1;
        bus.Add_Subt_result_i = d;
        bus.Carry_i           = c;
        bus.Exp_i             = e;
        @(negedge clk);
        bus.load_i = 1'b0;
    endtask

    task automatic wait_done(input int n0, output int lat, output res_t r, output logic busy_ok);
        int n;
        n       = n0;
        lat     = -1;
        r       = '0;
        busy_ok = 1'b1;
        while (n <= 60) begin
            if (bus.busy_o !== 1'b1) busy_ok = 1'b0;
            if (bus.done_o === 1'b1) begin
                lat = n;
                r   = sample();
                break;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_op(input string name, input logic [SWR-1:0] d, input logic c,
                            input logic [EW-1:0] e, input int n0, input logic [SWR-1:0] d_ignored,
                            input int ignore_at);
        res_t exp_r, got_r;
        int   exp_lat, got_lat;
        logic busy_ok;
        exp_r = model(d, c, e, exp_lat);
        if (ignore_at > 0) begin
            repeat (ignore_at - n0) @(negedge clk);
            bus.load_i            = 1'b1;
            bus.Add_Subt_result_i = d_ignored;
            bus.Carry_i           = 1'b1;
            bus.Exp_i             = 8'd3;
            @(negedge clk);
            bus.load_i = 1'b0;
            wait_done(ignore_at + 1, got_lat, got_r, busy_ok);
        end else begin
            wait_done(n0, got_lat, got_r, busy_ok);
        end
        n_total++;
        if (got_lat !== exp_lat)
            $display("FAIL %s latency: got %0d expected %0d", name, got_lat, exp_lat);
        else
            n_pass++;
        n_total++;
        if (got_r !== exp_r)
            $display("FAIL %s result: got %s expected %s", name, fmt(got_r), fmt(exp_r));
        else
            n_pass++;
        n_total++;
        if (busy_ok !== 1'b1)
            $display("FAIL %s busy: got dropped before done expected held 1", name);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({bus.busy_o, bus.done_o, sample()} !== '0)
            $display("FAIL reset_state: got busy=%0d done=%0d %s expected all 0",
                     bus.busy_o, bus.done_o, fmt(sample()));
        else
            n_pass++;
        rst = 1'b1;
    endtask

    task automatic test_carry();
        start_op(26'h2000000, 1'b1, 8'd100);
        check_op("carry_101", 26'h2000000, 1'b1, 8'd100, 1, '0, 0);
        start_op(26'h1234567, 1'b1, 8'd254);
        check_op("carry_ovf", 26'h1234567, 1'b1, 8'd254, 1, '0, 0);
        start_op(26'h0000000, 1'b1, 8'd255);
        check_op("carry_wrap", 26'h0000000, 1'b1, 8'd255, 1, '0, 0);
    endtask

    task automatic test_scan();
        start_op(26'h0400000, 1'b0, 8'd100);
        check_op("scan_k3", 26'h0400000, 1'b0, 8'd100, 1, '0, 0);
        start_op(26'h0000001, 1'b0, 8'd10);
        check_op("scan_k25_clamp", 26'h0000001, 1'b0, 8'd10, 1, '0, 0);
        start_op(26'h1000000, 1'b0, 8'd0);
        check_op("exp0_msb0", 26'h1000000, 1'b0, 8'd0, 1, '0, 0);
        start_op(26'h3FFFFFF, 1'b0, 8'd0);
        check_op("exp0_msb1", 26'h3FFFFFF, 1'b0, 8'd0, 1, '0, 0);
        start_op(26'h0000020, 1'b0, 8'd20);
        check_op("k20_eq_exp", 26'h0000020, 1'b0, 8'd20, 1, '0, 0);
    endtask

    task automatic test_zero_then_norm();
        res_t held;
        start_op(26'h0, 1'b0, 8'd50);
        check_op("zero", 26'h0, 1'b0, 8'd50, 1, '0, 0);
        held = sample();
        repeat (3) @(negedge clk);
        n_total++;
        if ({bus.done_o, bus.busy_o, sample()} !== {2'b00, held})
            $display("FAIL hold_after_done: got done=%0d busy=%0d %s expected 0 0 %s",
                     bus.done_o, bus.busy_o, fmt(sample()), fmt(held));
        else
            n_pass++;
        start_op(26'h2000000, 1'b0, 8'd50);
        check_op("zero_cleared_k0", 26'h2000000, 1'b0, 8'd50, 1, '0, 0);
    endtask

    task automatic test_busy_ignore();
        start_op(26'h0000020, 1'b0, 8'd100);
        check_op("load_while_busy", 26'h0000020, 1'b0, 8'd100, 1, 26'h2000000, 6);
    endtask

    task automatic test_reset_abort();
        logic saw_done;
        start_op(26'h0000020, 1'b0, 8'd100);
        repeat (8) @(negedge clk);
        rst = 1'b0;
        #1;
        n_total++;
        if ({bus.busy_o, bus.done_o, sample()} !== '0)
            $display("FAIL reset_abort_outputs: got busy=%0d done=%0d %s expected all 0",
                     bus.busy_o, bus.done_o, fmt(sample()));
        else
            n_pass++;
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done_o !== 1'b0) saw_done = 1'b1;
        end
        rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) saw_done = 1'b1;
        end
        n_total++;
        if (saw_done)
            $display("FAIL reset_abort_no_done: got done/busy activity expected none");
        else
            n_pass++;
        start_op(26'h0400000, 1'b0, 8'd100);
        check_op("after_reset_k3", 26'h0400000, 1'b0, 8'd100, 1, '0, 0);
    endtask

    task automatic test_back_to_back();
        res_t r;
        int   lat;
        logic busy_ok;
        logic accepted;
        start_op(26'h0400000, 1'b0, 8'd100);
        wait_done(1, lat, r, busy_ok);
        // Load offered during the DONE cycle must be dropped.
        bus.load_i            = 1'b1;
        bus.Add_Subt_result_i = 26'h0000001;
        bus.Carry_i           = 1'b0;
        bus.Exp_i             = 8'd200;
        @(negedge clk);
        bus.load_i = 1'b0;
        accepted   = 1'b0;
        repeat (3) begin
            if (bus.busy_o !== 1'b0) accepted = 1'b1;
            @(negedge clk);
        end
        n_total++;
        if (accepted)
            $display("FAIL load_in_done: got busy=1 after DONE-cycle load expected 0");
        else
            n_pass++;
        start_op(26'h0080000, 1'b0, 8'd40);
        wait_done(1, lat, r, busy_ok);
        start_op(26'h0001000, 1'b0, 8'd90);
        check_op("back_to_back", 26'h0001000, 1'b0, 8'd90, 1, '0, 0);
    endtask

    task automatic test_random();
        logic [SWR-1:0] d;
        logic           c;
        logic [EW-1:0]  e;
        for (int i = 0; i < 40; i++) begin
            d = SWR'($urandom) >> $urandom_range(0, SWR);
            c = ($urandom_range(0, 3) == 0);
            e = EW'($urandom_range(0, 254));
            start_op(d, c, e);
            check_op($sformatf("rand%0d", i), d, c, e, 1, '0, 0);
        end
    endtask

    initial begin
        n_pass                = 0;
        n_total               = 0;
        bus.load_i            = 1'b0;
        bus.Add_Subt_result_i = '0;
        bus.Carry_i           = 1'b0;
        bus.Exp_i             = '0;
        test_reset();
        test_carry();
        test_scan();
        test_zero_then_norm();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
